// File: rtl/ntp_offset_calc.sv
// rtl/ntp_offset_calc.sv - NTP four-timestamp offset/delay calculator
// Captures t1..t4 around one request/response exchange and reports offset, delay or an error code.
module ntp_offset_calc #(
  parameter int unsigned RESP_TIMEOUT = 100_000_000,
  parameter logic [63:0] MAX_DELAY    = 64'h0000_0000_4000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_local_time,
  input  logic        i_req_sent,
  input  logic        i_ntp_recv_sig,
  input  logic [63:0] i_ntp_server_get,
  input  logic [63:0] i_ntp_server_send,
  output logic [63:0] o_offset,
  output logic [63:0] o_delay,
  output logic        o_calc_valid,
  output logic        o_sync_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy,
  output logic [7:0]  o_stray_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RESP, S_DIFF, S_SUM, S_CHECK} state_t;

  localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);

  state_t r_state, w_next;

  logic [63:0] r_t1, r_t2, r_t3, r_t4;
  logic [64:0] r_d1, r_d2, r_rtt, r_proc;
  logic [63:0] r_off;
  logic [65:0] r_dly;
  logic [31:0] r_tmo_cnt;
  logic [63:0] r_offset, r_delay;
  logic        r_calc_valid, r_sync_err;
  logic [1:0]  r_err_code;
  logic [7:0]  r_stray_cnt;

  logic signed [65:0] w_sum66;
  logic [65:0]        w_dly66;
  logic               w_timeout, w_stray, w_ts_bad, w_dly_bad;

  assign w_sum66   = {r_d1[64], r_d1} + {r_d2[64], r_d2};
  assign w_dly66   = {r_rtt[64], r_rtt} - {r_proc[64], r_proc};
  assign w_timeout = (r_tmo_cnt == TMO_LAST);
  assign w_stray   = i_ntp_recv_sig && (r_state != S_WAIT_RESP);
  assign w_ts_bad  = (r_t2 == 64'd0) || (r_t3 == 64'd0) || (r_t3 < r_t2);
  // Sign bit set means negative delay; otherwise the magnitude compare is unsigned-safe.
  assign w_dly_bad = r_dly[65] || (r_dly > {2'b00, MAX_DELAY});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_req_sent) w_next = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (i_ntp_recv_sig)  w_next = S_DIFF;
        else if (i_req_sent) w_next = S_WAIT_RESP;
        else if (w_timeout)  w_next = S_IDLE;
      end
      S_DIFF:      w_next = S_SUM;
      S_SUM:       w_next = S_CHECK;
      S_CHECK:     w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_t1 <= '0; r_t2 <= '0; r_t3 <= '0; r_t4 <= '0;
      r_d1 <= '0; r_d2 <= '0; r_rtt <= '0; r_proc <= '0;
      r_off <= '0; r_dly <= '0; r_tmo_cnt <= '0;
      r_offset <= '0; r_delay <= '0;
      r_calc_valid <= 1'b0; r_sync_err <= 1'b0;
      r_err_code <= 2'd0; r_stray_cnt <= 8'd0;
    end else begin
      r_calc_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_sent) begin
            r_t1      <= i_local_time;
            r_tmo_cnt <= 32'd0;
          end
        end
        S_WAIT_RESP: begin
          // Receive outranks both a repeated request and the timeout.
          if (i_ntp_recv_sig) begin
            r_t4 <= i_local_time;
            r_t2 <= i_ntp_server_get;
            r_t3 <= i_ntp_server_send;
          end else if (i_req_sent) begin
            r_t1      <= i_local_time;
            r_tmo_cnt <= 32'd0;
          end else if (w_timeout) begin
            r_sync_err <= 1'b1;
            r_err_code <= 2'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
        end
        S_DIFF: begin
          r_d1   <= {1'b0, r_t2} - {1'b0, r_t1};
          r_d2   <= {1'b0, r_t3} - {1'b0, r_t4};
          r_rtt  <= {1'b0, r_t4} - {1'b0, r_t1};
          r_proc <= {1'b0, r_t3} - {1'b0, r_t2};
        end
        S_SUM: begin
          r_off <= 64'(w_sum66 >>> 1);
          r_dly <= w_dly66;
        end
        S_CHECK: begin
          if (w_ts_bad) begin
            r_sync_err <= 1'b1;
            r_err_code <= 2'd3;
          end else if (w_dly_bad) begin
            r_sync_err <= 1'b1;
            r_err_code <= 2'd2;
          end else begin
            r_calc_valid <= 1'b1;
            r_err_code   <= 2'd0;
            r_offset     <= r_off;
            r_delay      <= r_dly[63:0];
          end
        end
        default: ;
      endcase
      if (w_stray && (r_stray_cnt != 8'hFF)) r_stray_cnt <= r_stray_cnt + 8'd1;
    end
  end

  assign o_offset     = r_offset;
  assign o_delay      = r_delay;
  assign o_calc_valid = r_calc_valid;
  assign o_sync_err   = r_sync_err;
  assign o_err_code   = r_err_code;
  assign o_busy       = (r_state != S_IDLE);
  assign o_stray_cnt  = r_stray_cnt;

endmodule

// File: doc/ntp_offset_calc.md
NTP_OFFSET_CALC -- requirements
Module: ntp_offset_calc

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 100_000_000, meaning clock cycles to wait for a server response after a request.
REQ-002 SHALL have parameter MAX_DELAY, default 64'h0000_0000_4000_0000, meaning the largest acceptable round-trip delay (0.25 s in 32.32 format).
REQ-003 SHALL have port i_clk  in  1  clock.
REQ-004 SHALL have port i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_local_time  in  64  free-running local time, NTP 32.32 format.
REQ-006 SHALL have port i_req_sent  in  1  one-cycle pulse when an NTP request leaves the MAC.
REQ-007 SHALL have port i_ntp_recv_sig  in  1  one-cycle pulse from the receive parser when server timestamps are valid.
REQ-008 SHALL have port i_ntp_server_get  in  64  server receive timestamp t2.
REQ-009 SHALL have port i_ntp_server_send  in  64  server transmit timestamp t3.
REQ-010 SHALL have port o_offset  out  64  signed clock offset, two's complement 32.32.
REQ-011 SHALL have port o_delay  out  64  round-trip delay, 32.32.
REQ-012 SHALL have port o_calc_valid  out  1  one-cycle pulse when o_offset/o_delay are updated.
REQ-013 SHALL have port o_sync_err  out  1  one-cycle pulse on a failed exchange.
REQ-014 SHALL have port o_err_code  out  2  0 none, 1 timeout, 2 delay out of range, 3 server timestamps invalid.
REQ-015 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port o_stray_cnt  out  8  saturating count of ignored i_ntp_recv_sig pulses.

Function
REQ-017 SHALL implement states IDLE, WAIT_RESP, DIFF, SUM, CHECK.
REQ-018 In IDLE, i_req_sent SHALL capture t1=i_local_time, clear the timeout counter, and move to WAIT_RESP.
REQ-019 In WAIT_RESP, i_ntp_recv_sig at edge k SHALL capture t4=i_local_time, t2, and t3, and move to DIFF.
REQ-020 DIFF (edge k+1) SHALL register the 65-bit signed values d1=t2-t1, d2=t3-t4, rtt=t4-t1, and proc=t3-t2.
REQ-021 SUM (edge k+2) SHALL register offset=(d1+d2)>>>1, computed as a 66-bit sum with arithmetic shift and truncated to 64 bits, and delay=rtt-proc as 66-bit signed.
REQ-022 CHECK (edge k+3) SHALL evaluate the error classes in priority order:
- t2==0, t3==0, or t3<t2 (unsigned) -> code 3;
- delay negative or delay>MAX_DELAY -> code 2;
- otherwise success.
REQ-023 CHECK SHALL then return to IDLE.
REQ-024 On success, o_offset and o_delay SHALL update, o_calc_valid SHALL pulse, and o_err_code SHALL be 0; output latency is 3 cycles from the capture edge.
REQ-025 On error, o_sync_err SHALL pulse, o_err_code SHALL hold the code until the next o_calc_valid or o_sync_err, and o_offset/o_delay SHALL keep their previous values.
REQ-026 The timeout counter SHALL increment each WAIT_RESP cycle; on reaching RESP_TIMEOUT, o_sync_err SHALL pulse with code 1 and the state SHALL return to IDLE.
REQ-027 If i_ntp_recv_sig coincides with the timeout cycle, the receive SHALL win.
REQ-028 i_req_sent in WAIT_RESP without i_ntp_recv_sig SHALL recapture t1 and restart the timeout counter.
REQ-029 If i_req_sent and i_ntp_recv_sig arrive together in WAIT_RESP, the receive SHALL win and i_req_sent SHALL be dropped.
REQ-030 i_ntp_recv_sig in IDLE, DIFF, SUM or CHECK SHALL be ignored and SHALL increment o_stray_cnt, saturating at 255.
REQ-031 i_req_sent in DIFF, SUM or CHECK SHALL be ignored.
REQ-032 o_calc_valid and o_sync_err SHALL never be high in the same cycle.

Reset
REQ-033 Assertion of i_rst_n low SHALL immediately force IDLE and set every output and internal register to 0, including during a calculation in progress.
REQ-034 After reset release, the first i_req_sent SHALL be accepted on the next rising edge.

Verification
REQ-035 The bench SHALL cover positive offset: t1=0x1_0000_0000, t2=0x1_8000_0000, t3=0x1_9000_0000, t4=0x1_2000_0000 -> o_calc_valid 3 cycles after capture, o_offset=0x7800_0000, o_delay=0x1000_0000.
REQ-036 The bench SHALL cover negative offset: t1=0x2_0000_0000, t2=t3=0x1_0000_0000, t4=0x2_2000_0000 -> o_offset=0xFFFF_FFFE_F000_0000, o_delay=0x2000_0000.
REQ-037 The bench SHALL cover excess delay: t1=0x1_0000_0000, t2=t3=0x5_0000_0000, t4=0x1_8000_0000 -> o_sync_err, o_err_code=2, o_offset unchanged.
REQ-038 The bench SHALL cover timeout: RESP_TIMEOUT=16, i_req_sent, no receive -> o_sync_err with code 1 exactly 16 cycles later; a receive on that cycle instead yields o_calc_valid.
REQ-039 The bench SHALL cover stray and invalid inputs:
- i_ntp_recv_sig in IDLE -> no pulses, o_stray_cnt=1;
- t3=0x1_0000_0000 < t2=0x2_0000_0000 -> code 3.
REQ-040 The bench SHALL cover reset mid-operation: i_rst_n low during SUM -> all outputs 0, o_busy=0; a new exchange then succeeds normally.
